lab7_soc_sysid_checker: RTL and testbench

LAB7_SOC_SYSID_CHECKER -- requirements
Module: lab7_soc_sysid_checker

---
 rtl/lab7_soc_sysid_pkg.sv | 20 ++
 rtl/lab7_soc_sysid_checker.sv | 138 +++++++++++++
 tb/tb_lab7_soc_sysid_checker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lab7_soc_sysid_pkg.sv
// Shared types and constants for the sysid checker.
// Holds the FSM state enum, sysid word addresses and default words.
package lab7_soc_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TS = 32'h54FF_C716;

endpackage

// File: rtl/lab7_soc_sysid_checker.sv
// Reads ID and timestamp from an Avalon-MM sysid slave and compares them.
// Ports: clock/reset_n, start, av_* master, busy/done/pass/*_ok, words, count.
module lab7_soc_sysid_checker
    import lab7_soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS  = DEFAULT_TS,
    parameter int unsigned READ_LATENCY = 0,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [7:0]  check_count
);

    // Final wait-cycle index; unused when READ_LATENCY is 0.
    localparam logic [2:0] LAST =
        (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       auto_pend;
    logic       launch;
    logic       cap_id;
    logic       cap_ts;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        launch     = 1'b0;
        cap_id     = 1'b0;
        cap_ts     = 1'b0;
        av_read    = 1'b0;
        av_address = SYSID_ADDR_ID;
        busy       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // auto_pend is only ever set on the first edge after reset
                if (start || auto_pend) begin
                    launch  = 1'b1;
                    state_d = REQ_ID;
                end
            end
            REQ_ID: begin
                av_read = 1'b1;
                busy    = 1'b1;
                cnt_d   = 3'd0;
                if (READ_LATENCY == 0) begin
                    cap_id  = 1'b1;
                    state_d = REQ_TS;
                end else begin
                    state_d = WAIT_ID;
                end
            end
            WAIT_ID: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    cap_id  = 1'b1;
                    state_d = REQ_TS;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            REQ_TS: begin
                av_read    = 1'b1;
                av_address = SYSID_ADDR_TS;
                busy       = 1'b1;
                cnt_d      = 3'd0;
                if (READ_LATENCY == 0) begin
                    cap_ts  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT_TS;
                end
            end
            WAIT_TS: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    cap_ts  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            auto_pend   <= AUTO_START;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            check_count <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            auto_pend <= 1'b0;
            if (launch) begin
                done  <= 1'b0;
                pass  <= 1'b0;
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
            end
            if (cap_id) begin
                id_value <= av_readdata;
            end
            // ts is compared straight off the bus so results land with DONE
            if (cap_ts) begin
                ts_value    <= av_readdata;
                done        <= 1'b1;
                id_ok       <= (id_value == EXPECTED_ID);
                ts_ok       <= (av_readdata == EXPECTED_TS);
                pass        <= (id_value == EXPECTED_ID) &&
                               (av_readdata == EXPECTED_TS);
                check_count <= check_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lab7_soc_sysid_checker.sv
// Directed bench for the sysid checker: zero-latency auto-start instance
// plus a latency-2 manual-start instance with a delayed slave model.
module tb_lab7_soc_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'h54FF_C716;
    localparam logic [31:0] TS_BAD  = 32'h54FF_C717;
    localparam logic [31:0] ID2     = 32'h1234_5678;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    // instance 0: defaults
    logic        reset_n0, start0;
    logic        av_address0, av_read0;
    logic [31:0] av_readdata0;
    logic        busy0, done0, pass0, id_ok0, ts_ok0;
    logic [31:0] id_value0, ts_value0;
    logic [7:0]  check_count0;
    logic [31:0] ts_model0;

    assign av_readdata0 = !av_read0 ? 32'hDEAD_BEEF :
                          (av_address0 ? ts_model0 : 32'h0000_0000);

    lab7_soc_sysid_checker dut0 (
        .clock       (clock),
        .reset_n     (reset_n0),
        .start       (start0),
        .av_address  (av_address0),
        .av_read     (av_read0),
        .av_readdata (av_readdata0),
        .busy        (busy0),
        .done        (done0),
        .pass        (pass0),
        .id_ok       (id_ok0),
        .ts_ok       (ts_ok0),
        .id_value    (id_value0),
        .ts_value    (ts_value0),
        .check_count (check_count0)
    );

    // instance 2: latency 2, no auto start
    logic        reset_n2, start2;
    logic        av_address2, av_read2;
    logic [31:0] av_readdata2;
    logic        busy2, done2, pass2, id_ok2, ts_ok2;
    logic [31:0] id_value2, ts_value2;
    logic [7:0]  check_count2;
    logic [1:0]  p_rd = 2'b00;
    logic [1:0]  p_addr = 2'b00;
    int          rd2_cnt = 0;

    always @(posedge clock) begin
        p_rd   <= {p_rd[0], av_read2};
        p_addr <= {p_addr[0], av_address2};
        if (av_read2) rd2_cnt <= rd2_cnt + 1;
    end

    assign av_readdata2 = !p_rd[1] ? 32'hBAD0_0001 :
                          (p_addr[1] ? TS_GOOD : ID2);

    lab7_soc_sysid_checker #(
        .EXPECTED_ID  (ID2),
        .READ_LATENCY (2),
        .AUTO_START   (1'b0)
    ) dut2 (
        .clock       (clock),
        .reset_n     (reset_n2),
        .start       (start2),
        .av_address  (av_address2),
        .av_read     (av_read2),
        .av_readdata (av_readdata2),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .id_ok       (id_ok2),
        .ts_ok       (ts_ok2),
        .id_value    (id_value2),
        .ts_value    (ts_value2),
        .check_count (check_count2)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // flags = {busy, done, pass, id_ok, ts_ok, av_read, av_address}
    typedef struct {
        logic        start;
        logic [31:0] ts;
        logic [6:0]  flags;
        logic [7:0]  cnt;
        logic [31:0] tsv;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [63:0] obs0();
        return 64'({busy0, done0, pass0, id_ok0, ts_ok0,
                    av_read0, av_address0, check_count0, ts_value0});
    endfunction

    function automatic logic [63:0] flags2();
        return 64'({busy2, done2, pass2, id_ok2, ts_ok2,
                    av_read2, av_address2, check_count2});
    endfunction

    initial begin
        int snap;
        tbl[0]  = '{1'b0, TS_GOOD, 7'b1000010, 8'd0, 32'h0};
        tbl[1]  = '{1'b0, TS_GOOD, 7'b1000011, 8'd0, 32'h0};
        tbl[2]  = '{1'b0, TS_GOOD, 7'b0111100, 8'd1, TS_GOOD};
        tbl[3]  = '{1'b0, TS_GOOD, 7'b0111100, 8'd1, TS_GOOD};
        tbl[4]  = '{1'b1, TS_BAD,  7'b1000010, 8'd1, TS_GOOD};
        tbl[5]  = '{1'b1, TS_BAD,  7'b1000011, 8'd1, TS_GOOD};
        tbl[6]  = '{1'b1, TS_BAD,  7'b0101000, 8'd2, TS_BAD};
        tbl[7]  = '{1'b1, TS_GOOD, 7'b1000010, 8'd2, TS_BAD};
        tbl[8]  = '{1'b0, TS_GOOD, 7'b1000011, 8'd2, TS_BAD};
        tbl[9]  = '{1'b0, TS_GOOD, 7'b0111100, 8'd3, TS_GOOD};
        tbl[10] = '{1'b0, TS_GOOD, 7'b0111100, 8'd3, TS_GOOD};

        reset_n0  = 1'b0;
        reset_n2  = 1'b0;
        start0    = 1'b0;
        start2    = 1'b0;
        ts_model0 = TS_GOOD;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst0", obs0(), 64'd0);
        chk("rst2", 64'({flags2(), id_value2, ts_value2}), 64'd0);
        reset_n0 = 1'b1;
        reset_n2 = 1'b1;

        for (int i = 0; i < 11; i++) begin
            start0    = tbl[i].start;
            ts_model0 = tbl[i].ts;
            tick();
            chk($sformatf("row%0d", i), obs0(),
                64'({tbl[i].flags, tbl[i].cnt, tbl[i].tsv}));
        end
        chk("id0_val", 64'(id_value0), 64'd0);

        // held start relaunches every third edge; 253 more checks wrap
        start0 = 1'b1;
        for (int n = 0; n < 252; n++) begin
            repeat (3) tick();
        end
        chk("cnt255", 64'({done0, check_count0}), 64'({1'b1, 8'd255}));
        repeat (3) tick();
        start0 = 1'b0;
        chk("wrap", obs0(), 64'({7'b0111100, 8'd0, TS_GOOD}));
        tick();
        chk("wrap_hold", 64'({done0, check_count0, id_value0}),
            64'({1'b1, 8'd0, 32'd0}));

        // latency-2 instance never auto-launched
        chk("noauto", 64'({flags2(), 32'(rd2_cnt)}), 64'd0);

        start2 = 1'b1;
        tick();
        chk("l2_launch", flags2(), 64'({7'b1000010, 8'd0}));
        for (int i = 1; i < 6; i++) begin
            tick();
            chk($sformatf("l2_busy%0d", i), 64'({busy2, done2}),
                64'({1'b1, 1'b0}));
        end
        tick();
        chk("l2_done", flags2(), 64'({7'b0111100, 8'd1}));
        chk("l2_vals", {id_value2, ts_value2}, {ID2, TS_GOOD});
        chk("l2_reads", 64'(rd2_cnt), 64'd2);
        start2 = 1'b0;
        tick();
        chk("l2_hold", flags2(), 64'({7'b0111100, 8'd1}));

        // reset while waiting for the timestamp
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (4) tick();
        chk("l2_wait_ts", 64'({busy2, av_read2, done2}),
            64'({1'b1, 1'b0, 1'b0}));
        snap = rd2_cnt;
        chk("l2_rd_before", 64'(snap), 64'd4);
        #2;
        reset_n2 = 1'b0;
        #1;
        chk("l2_async_rst", 64'({flags2(), id_value2, ts_value2}), 64'd0);
        @(negedge clock);
        reset_n2 = 1'b1;
        repeat (5) tick();
        chk("l2_post_rst", 64'({flags2(), 32'(rd2_cnt)}),
            64'({15'd0, 32'(snap)}));

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (6) tick();
        chk("l2_relaunch", 64'({flags2(), ts_value2}),
            64'({7'b0111100, 8'd1, TS_GOOD}));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
